csr_exec_unit: RTL and testbench

CSR_EXEC_UNIT -- requirements
Module: csr_exec_unit

---
 rtl/csr_exec_unit_pkg.sv | 40 ++++
 rtl/csr_exec_unit_access_check.sv | 34 +++
 rtl/csr_exec_unit.sv | 138 +++++++++++++
 tb/tb_csr_exec_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_exec_unit_pkg.sv
// CSR execute unit shared types.
// Opcodes, privilege modes and the latched request bundle.
package csr_exec_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [11:0] csraddr_t;

  typedef enum logic [2:0] {
    OP_RSV0 = 3'b000,
    OP_RW   = 3'b001,
    OP_RS   = 3'b010,
    OP_RC   = 3'b011,
    OP_RSV4 = 3'b100,
    OP_RWI  = 3'b101,
    OP_RSI  = 3'b110,
    OP_RCI  = 3'b111
  } csr_op_t;

  typedef enum logic [1:0] {
    MODE_U = 2'b00,
    MODE_S = 2'b01,
    MODE_H = 2'b10,
    MODE_M = 2'b11
  } cpu_mode_t;

  typedef struct packed {
    csr_op_t   op;
    csraddr_t  addr;
    word_t     rs1;
    logic [4:0] zimm;
    logic [4:0] rs1_idx;
    word_t     pc;
    cpu_mode_t mode;
  } csr_req_t;

  function automatic word_t csr_src(input csr_req_t r);
    return r.op[2] ? {27'b0, r.zimm} : r.rs1;
  endfunction

endpackage

// File: rtl/csr_exec_unit_access_check.sv
// CSR legality and write-intent decode.
// Purely combinational; fed from the latched request.
module csr_access_check
  import csr_exec_unit_pkg::*;
(
  input  csr_op_t    op,
  input  csraddr_t   addr,
  input  logic [4:0] rs1_idx,
  input  logic [4:0] zimm,
  input  cpu_mode_t  mode,
  output logic       wr_intent,
  output logic       illegal
);

  always_comb begin
    wr_intent = 1'b0;
    unique case (op)
      OP_RW, OP_RWI:  wr_intent = 1'b1;
      OP_RS, OP_RC:   wr_intent = (rs1_idx != 5'd0);
      OP_RSI, OP_RCI: wr_intent = (zimm != 5'd0);
      default:        wr_intent = 1'b0;
    endcase
  end

  logic priv_bad;
  logic ro_bad;
  logic op_bad;

  assign priv_bad = addr[9:8] > 2'(mode);
  assign ro_bad   = (addr[11:10] == 2'b11) && wr_intent;
  assign op_bad   = (op == OP_RSV0) || (op == OP_RSV4);
  assign illegal  = priv_bad || ro_bad || op_bad;

endmodule

// File: rtl/csr_exec_unit.sv
// CSR execute unit: read, optional write, respond.
// Four-state FSM with kill and async reset.
module csr_exec_unit
  import csr_exec_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  csr_op_t    req_op,
  input  csraddr_t   req_addr,
  input  word_t      req_rs1,
  input  logic [4:0] req_zimm,
  input  logic [4:0] req_rs1_idx,
  input  word_t      req_pc,
  input  cpu_mode_t  cpu_mode,
  input  logic       kill,
  output csraddr_t   csr_raddr,
  input  word_t      csr_rdata,
  output csraddr_t   csr_waddr,
  output logic       csr_we,
  output word_t      csr_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output word_t      resp_rdata,
  output logic       resp_illegal,
  output logic       resp_flush,
  output word_t      resp_redirect_pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t   state;
  state_t   state_nx;
  csr_req_t req_q;
  word_t    old_q;
  word_t    src;
  word_t    new_val;
  logic     wr_intent;
  logic     illegal;
  logic     do_write;
  logic     accept;

  csr_access_check u_chk (
    .op        (req_q.op),
    .addr      (req_q.addr),
    .rs1_idx   (req_q.rs1_idx),
    .zimm      (req_q.zimm),
    .mode      (req_q.mode),
    .wr_intent (wr_intent),
    .illegal   (illegal)
  );

  assign do_write = wr_intent && !illegal;
  assign accept   = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (kill && state != S_IDLE) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (accept) state_nx = S_READ;
        S_READ:  state_nx = do_write ? S_WRITE : S_RESP;
        S_WRITE: state_nx = S_RESP;
        S_RESP:  if (resp_ready) state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      old_q <= '0;
    end else begin
      if (accept) begin
        req_q <= '{op: req_op, addr: req_addr,
                   rs1: req_rs1, zimm: req_zimm,
                   rs1_idx: req_rs1_idx, pc: req_pc,
                   mode: cpu_mode};
      end
      if (state == S_READ) old_q <= csr_rdata;
    end
  end

  // op[1:0] selects write/set/clear for both register and immediate forms
  always_comb begin
    src     = csr_src(req_q);
    new_val = src;
    unique case (1'b1)
      req_q.op[1:0] == 2'b10: new_val = old_q | src;
      req_q.op[1:0] == 2'b11: new_val = old_q & ~src;
      default:                new_val = src;
    endcase
  end

  always_comb begin
    req_ready        = 1'b0;
    csr_raddr        = '0;
    csr_waddr        = '0;
    csr_we           = 1'b0;
    csr_wdata        = '0;
    resp_valid       = 1'b0;
    resp_rdata       = '0;
    resp_illegal     = 1'b0;
    resp_flush       = 1'b0;
    resp_redirect_pc = '0;
    unique case (state)
      S_IDLE: req_ready = !kill;
      S_READ: csr_raddr = req_q.addr;
      S_WRITE: begin
        csr_waddr = req_q.addr;
        csr_we    = !kill;
        csr_wdata = new_val;
      end
      S_RESP: begin
        resp_valid       = !kill;
        resp_rdata       = illegal ? '0 : old_q;
        resp_illegal     = illegal;
        resp_flush       = do_write;
        resp_redirect_pc = req_q.pc + 32'd4;
      end
      default: req_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_csr_exec_unit.sv
// Directed bench for csr_exec_unit.
// Hand-computed vectors, one checking task.
module tb_csr_exec_unit;
  import csr_exec_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid;
  logic       req_ready;
  csr_op_t    req_op;
  csraddr_t   req_addr;
  word_t      req_rs1;
  logic [4:0] req_zimm;
  logic [4:0] req_rs1_idx;
  word_t      req_pc;
  cpu_mode_t  cpu_mode;
  logic       kill;
  csraddr_t   csr_raddr;
  word_t      csr_rdata;
  csraddr_t   csr_waddr;
  logic       csr_we;
  word_t      csr_wdata;
  logic       resp_valid;
  logic       resp_ready;
  word_t      resp_rdata;
  logic       resp_illegal;
  logic       resp_flush;
  word_t      resp_redirect_pc;

  always #5 clk = ~clk;

  csr_exec_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .req_rs1          (req_rs1),
    .req_zimm         (req_zimm),
    .req_rs1_idx      (req_rs1_idx),
    .req_pc           (req_pc),
    .cpu_mode         (cpu_mode),
    .kill             (kill),
    .csr_raddr        (csr_raddr),
    .csr_rdata        (csr_rdata),
    .csr_waddr        (csr_waddr),
    .csr_we           (csr_we),
    .csr_wdata        (csr_wdata),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_rdata       (resp_rdata),
    .resp_illegal     (resp_illegal),
    .resp_flush       (resp_flush),
    .resp_redirect_pc (resp_redirect_pc)
  );

  int n_cmp = 0;
  int n_err = 0;

  int    we_cyc, we_cnt, rv_cyc;
  word_t wdata_o, waddr_o, raddr_o;
  word_t rdata_o, redir_o;
  logic  ill_o, flush_o;

  task automatic expect_eq(input string tag,
                           input logic [31:0] obs,
                           input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               tag, obs, exp);
    end
  endtask

  task automatic issue(input csr_op_t op, input csraddr_t a,
                       input word_t rs1, input logic [4:0] zi,
                       input logic [4:0] idx, input word_t pc,
                       input cpu_mode_t m, input word_t rf);
    @(negedge clk);
    req_op = op; req_addr = a; req_rs1 = rs1;
    req_zimm = zi; req_rs1_idx = idx; req_pc = pc;
    cpu_mode = m; csr_rdata = rf; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = '0; req_rs1 = '1; req_zimm = '0;
    req_rs1_idx = '0; req_pc = '0; cpu_mode = MODE_U;
    we_cyc = 0; we_cnt = 0; rv_cyc = 0; raddr_o = '0;
    wdata_o = '0; waddr_o = '0;
    for (int c = 1; c <= 20 && rv_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) raddr_o = 32'(csr_raddr);
      if (csr_we) begin
        we_cnt++;
        if (we_cyc == 0) we_cyc = c;
        wdata_o = csr_wdata;
        waddr_o = 32'(csr_waddr);
      end
      if (resp_valid) begin
        rv_cyc  = c;
        rdata_o = resp_rdata;
        ill_o   = resp_illegal;
        flush_o = resp_flush;
        redir_o = resp_redirect_pc;
      end
    end
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic start_rw();
    @(negedge clk);
    req_op = OP_RW; req_addr = 12'h340; req_rs1 = 32'h1;
    req_rs1_idx = 5'd1; cpu_mode = MODE_M; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 0x00000000 want 0x00000001");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hold_bad;
    logic rdy_seen;
    req_valid = 0; req_op = OP_RW; req_addr = '0;
    req_rs1 = '0; req_zimm = '0; req_rs1_idx = '0;
    req_pc = '0; cpu_mode = MODE_M; kill = 0;
    csr_rdata = '0; resp_ready = 0;
    #12;
    expect_eq("rst_ready", req_ready, 1);
    expect_eq("rst_we", csr_we, 0);
    expect_eq("rst_rv", resp_valid, 0);
    expect_eq("rst_ill", resp_illegal, 0);
    expect_eq("rst_flush", resp_flush, 0);
    expect_eq("rst_rdata", resp_rdata, 0);
    expect_eq("rst_redir", resp_redirect_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OP_RW, 12'h340, 32'h12345678, 5'd0, 5'd5,
          32'h1000, MODE_M, 32'hAAAA0000);
    expect_eq("s1_raddr", raddr_o, 32'h340);
    expect_eq("s1_we_cyc", 32'(we_cyc), 2);
    expect_eq("s1_we_cnt", 32'(we_cnt), 1);
    expect_eq("s1_wdata", wdata_o, 32'h12345678);
    expect_eq("s1_waddr", waddr_o, 32'h340);
    expect_eq("s1_rv_cyc", 32'(rv_cyc), 3);
    expect_eq("s1_rdata", rdata_o, 32'hAAAA0000);
    expect_eq("s1_ill", ill_o, 0);
    expect_eq("s1_flush", flush_o, 1);
    expect_eq("s1_redir", redir_o, 32'h1004);
    finish_resp();

    issue(OP_RS, 12'hF14, 32'hDEADBEEF, 5'd0, 5'd0,
          32'h2000, MODE_M, 32'h0);
    expect_eq("s2_we_cnt", 32'(we_cnt), 0);
    expect_eq("s2_rv_cyc", 32'(rv_cyc), 2);
    expect_eq("s2_ill", ill_o, 0);
    expect_eq("s2_rdata", rdata_o, 0);
    expect_eq("s2_flush", flush_o, 0);
    expect_eq("s2_redir", redir_o, 32'h2004);
    finish_resp();

    issue(OP_RCI, 12'h300, 32'h0, 5'd5, 5'd0,
          32'h3000, MODE_U, 32'h5555AAAA);
    expect_eq("s3_ill", ill_o, 1);
    expect_eq("s3_we_cnt", 32'(we_cnt), 0);
    expect_eq("s3_rdata", rdata_o, 0);
    expect_eq("s3_flush", flush_o, 0);
    expect_eq("s3_rv_cyc", 32'(rv_cyc), 2);
    finish_resp();

    issue(OP_RC, 12'h140, 32'h0000FF00, 5'd0, 5'd3,
          32'hFFFFFFFC, MODE_S, 32'hFFFFFFFF);
    expect_eq("s4_wdata", wdata_o, 32'hFFFF00FF);
    expect_eq("s4_redir", redir_o, 32'h0);
    expect_eq("s4_rdata", rdata_o, 32'hFFFFFFFF);
    expect_eq("s4_flush", flush_o, 1);
    expect_eq("s4_ill", ill_o, 0);
    finish_resp();

    issue(csr_op_t'(3'b100), 12'h340, 32'h1, 5'd1, 5'd1,
          32'h0, MODE_M, 32'h1234);
    expect_eq("op4_ill", ill_o, 1);
    expect_eq("op4_we_cnt", 32'(we_cnt), 0);
    expect_eq("op4_rv_cyc", 32'(rv_cyc), 2);
    finish_resp();

    issue(OP_RWI, 12'hC00, 32'h0, 5'd0, 5'd0,
          32'h0, MODE_U, 32'h777);
    expect_eq("rwi_ro_ill", ill_o, 1);
    expect_eq("rwi_ro_we", 32'(we_cnt), 0);
    finish_resp();

    issue(OP_RSI, 12'hC00, 32'h0, 5'd0, 5'd0,
          32'h0, MODE_U, 32'h777);
    expect_eq("rsi0_ill", ill_o, 0);
    expect_eq("rsi0_rdata", rdata_o, 32'h777);
    expect_eq("rsi0_flush", flush_o, 0);
    finish_resp();

    issue(OP_RSI, 12'h305, 32'hFFFF0000, 5'd3, 5'd0,
          32'h100, MODE_M, 32'h10);
    expect_eq("rsi_wdata", wdata_o, 32'h13);
    expect_eq("rsi_flush", flush_o, 1);
    finish_resp();

    issue(OP_RW, 12'h340, 32'h1, 5'd0, 5'd1,
          32'h0, MODE_S, 32'h9);
    expect_eq("s_on_m_ill", ill_o, 1);
    expect_eq("s_on_m_we", 32'(we_cnt), 0);
    finish_resp();

    start_rw();
    expect_eq("s5_we_pre", csr_we, 1);
    kill = 1'b1;
    #1;
    expect_eq("s5_kill_we", csr_we, 0);
    @(posedge clk);
    #1;
    kill = 1'b0;
    #1;
    expect_eq("s5_kill_idle", req_ready, 1);
    expect_eq("s5_kill_rv", resp_valid, 0);

    start_rw();
    expect_eq("s5_we_pre2", csr_we, 1);
    rst_n = 1'b0;
    #1;
    expect_eq("s5_rst_we", csr_we, 0);
    expect_eq("s5_rst_idle", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_eq("s5_rst_rv", resp_valid, 0);
    expect_eq("s5_rst_ready", req_ready, 1);

    issue(OP_RW, 12'h341, 32'hCAFE0001, 5'd0, 5'd2,
          32'h4000, MODE_M, 32'h11);
    req_valid = 1'b1;
    expect_eq("s6_rv_cyc", 32'(rv_cyc), 3);
    hold_bad = 1'b0;
    rdy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h11 ||
          resp_flush !== 1'b1 || resp_illegal !== 1'b0 ||
          resp_redirect_pc !== 32'h4004)
        hold_bad = 1'b1;
      if (req_ready) rdy_seen = 1'b1;
      if (csr_we) we_cnt++;
    end
    expect_eq("s6_hold", hold_bad, 0);
    expect_eq("s6_ready", rdy_seen, 0);
    expect_eq("s6_we_cnt", 32'(we_cnt), 1);
    finish_resp();
    @(negedge clk);
    expect_eq("s6_idle", req_ready, 1);
    expect_eq("s6_rv_low", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
